// File: rtl/k12a_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// k12a_mem_ctrl_pkg
// Shared types and constants for the K12A memory controller.
//   mem_ctrl_state_t : controller FSM states
//   WAIT_STATES_MAX  : largest supported wait-state count
//   wait_cnt_width() : width of the ACCESS wait counter for a given count
// ---------------------------------------------------------------------------
package k12a_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_SETUP  = 2'd1,
        MC_ACCESS = 2'd2,
        MC_HOLD   = 2'd3
    } mem_ctrl_state_t;

    localparam int unsigned WAIT_STATES_MAX = 15;

    // max(1, clog2(ws+1)) so a zero-wait build still has a 1-bit counter.
    function automatic int unsigned wait_cnt_width(input int unsigned ws);
        int unsigned w;
        w = $clog2(ws + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/k12a_mem_ctrl.sv
// ---------------------------------------------------------------------------
// k12a_mem_ctrl
// Responder on the CPU address bus. Latches an address (and write data) when a
// single read or write request is seen in IDLE, then runs an asynchronous SRAM
// cycle SETUP -> ACCESS (WAIT_STATES+1 cycles) -> HOLD -> IDLE.
//
// Ports
//   clock, reset_n         : system clock, async active-low reset
//   addr_bus               : address, sampled on request acceptance only
//   mem_read_req/write_req : level requests, sampled in IDLE
//   mem_wdata              : write data, sampled with the address
//   mem_rdata              : last completed read data
//   mem_done               : one-cycle pulse in HOLD
//   mem_busy               : high outside IDLE
//   mem_err                : one-cycle pulse after read+write requested together
//   sram_addr/data/ce_n/oe_n/we_n : external 64K x 8 SRAM pins
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, SRAM deselected
// SETUP  | CE asserted (OE for reads), data bus released for turnaround
// ACCESS | strobe asserted, wait counter runs down to zero
// HOLD   | strobes released, write data still held, mem_done pulses
// ---------------------------------------------------------------------------
module k12a_mem_ctrl
    import k12a_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_done,
    output logic        mem_busy,
    output logic        mem_err,
    output logic [15:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int unsigned     CW        = wait_cnt_width(WAIT_STATES);
    localparam logic [CW-1:0]   WAIT_LOAD = CW'(WAIT_STATES);

    mem_ctrl_state_t state_q, state_d;
    logic            write_q, write_d;
    logic [15:0]     addr_q,  addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [CW-1:0]   wait_q,  wait_d;
    logic            err_q,   err_d;
    logic            accept;
    logic            wait_done;
    logic            data_drive;

    // Exactly one request; both together is a protocol error.
    assign accept    = (state_q == MC_IDLE) && (mem_read_req ^ mem_write_req);
    assign wait_done = (wait_q == '0);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MC_IDLE:   if (accept) state_d = MC_SETUP;
            MC_SETUP:  state_d = MC_ACCESS;
            MC_ACCESS: if (wait_done) state_d = MC_HOLD;
            MC_HOLD:   state_d = MC_IDLE;
            default:   state_d = MC_IDLE;
        endcase
    end

    // Output decode: strobes come straight from registered state, so no glitches.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        mem_done   = 1'b0;
        mem_busy   = 1'b1;
        data_drive = 1'b0;
        case (state_q)
            MC_IDLE: begin
                mem_busy = 1'b0;
            end
            MC_SETUP: begin
                sram_ce_n = 1'b0;
                sram_oe_n = write_q;
            end
            MC_ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = write_q;
                sram_we_n  = ~write_q;
                data_drive = write_q;
            end
            MC_HOLD: begin
                sram_ce_n  = 1'b0;
                mem_done   = 1'b1;
                data_drive = write_q;
            end
            default: begin
                mem_busy = 1'b0;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        err_d   = (state_q == MC_IDLE) && mem_read_req && mem_write_req;
        if (accept) begin
            write_d = mem_write_req;
            addr_d  = addr_bus;
            wdata_d = mem_wdata;
        end
        if (state_q == MC_SETUP) begin
            wait_d = WAIT_LOAD;
        end
        if (state_q == MC_ACCESS) begin
            if (wait_done) begin
                if (!write_q) rdata_d = sram_data;
            end else begin
                wait_d = wait_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign sram_addr = addr_q;
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;
    assign sram_data = data_drive ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_k12a_mem_ctrl.sv
module tb_k12a_mem_ctrl;

    localparam int WA = 2;
    localparam int WB = 0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- DUT A (WAIT_STATES = 2) ----------------
    logic [15:0] a_addr_bus = '0;
    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [7:0]  a_wdata = '0;
    logic [7:0]  a_rdata;
    logic        a_done, a_busy, a_err;
    logic [15:0] a_sram_addr;
    wire  [7:0]  a_sram_data;
    logic        a_ce_n, a_oe_n, a_we_n;

    k12a_mem_ctrl #(.WAIT_STATES(WA)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .addr_bus(a_addr_bus),
        .mem_read_req(a_rd), .mem_write_req(a_wr), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .mem_done(a_done), .mem_busy(a_busy), .mem_err(a_err),
        .sram_addr(a_sram_addr), .sram_data(a_sram_data),
        .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n));

    // ---------------- DUT B (WAIT_STATES = 0) ----------------
    logic [15:0] b_addr_bus = '0;
    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [7:0]  b_wdata = '0;
    logic [7:0]  b_rdata;
    logic        b_done, b_busy, b_err;
    logic [15:0] b_sram_addr;
    wire  [7:0]  b_sram_data;
    logic        b_ce_n, b_oe_n, b_we_n;

    k12a_mem_ctrl #(.WAIT_STATES(WB)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .addr_bus(b_addr_bus),
        .mem_read_req(b_rd), .mem_write_req(b_wr), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .mem_done(b_done), .mem_busy(b_busy), .mem_err(b_err),
        .sram_addr(b_sram_addr), .sram_data(b_sram_data),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n));

    // ---------------- SRAM models ----------------
    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h1234) return 8'h5A;
        if (a == 16'h0000) return 8'hFF;
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'hA5;
    endfunction

    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) mem_a[i] = init_val(16'(i));
        forever begin
            @(posedge clock);
            if (!a_ce_n && !a_we_n) mem_a[a_sram_addr] <= a_sram_data;
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem_b[i] = init_val(16'(i));
        forever begin
            @(posedge clock);
            if (!b_ce_n && !b_we_n) mem_b[b_sram_addr] <= b_sram_data;
        end
    end

    assign a_sram_data = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sram_addr] : 8'hzz;
    assign b_sram_data = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sram_addr] : 8'hzz;

    // ---------------- Reference model ----------------
    logic [7:0] ref_mem [0:65535];
    logic [7:0] ref_rdata;

    // Runs one transaction on DUT A and reports what was observed; no checking here.
    task automatic run_txn(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                           output int done_k, output int busy_n, output int oe_lo,
                           output int we_lo, output int drv_n, output int first_drv,
                           output bit addr_ok, output logic [7:0] rd_at_done);
        done_k = -1; busy_n = 0; oe_lo = 0; we_lo = 0; drv_n = 0; first_drv = -1;
        addr_ok = 1'b1; rd_at_done = 8'hxx;
        @(posedge clock); #1;
        a_addr_bus = a; a_wdata = d; a_rd = !is_wr; a_wr = is_wr;
        @(posedge clock); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        a_addr_bus = 16'($urandom); a_wdata = 8'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (a_busy) busy_n++;
            if (!a_oe_n) oe_lo++;
            if (!a_we_n) we_lo++;
            if (is_wr && a_sram_data === d) begin
                drv_n++;
                if (first_drv < 0) first_drv = k;
            end
            if (a_busy && a_sram_addr !== a) addr_ok = 1'b0;
            if (a_done && done_k < 0) begin done_k = k; rd_at_done = a_rdata; end
            if (!a_busy) break;
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (a_ce_n !== 1'b1 || a_oe_n !== 1'b1 || a_we_n !== 1'b1)
            $display("FAIL reset_strobes: ce/oe/we=%b%b%b expected 111", a_ce_n, a_oe_n, a_we_n);
            else n_pass++;
        n_total++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0)
            $display("FAIL reset_flags: busy/done/err=%b%b%b expected 000", a_busy, a_done, a_err);
            else n_pass++;
        n_total++; if (a_rdata !== 8'h00 || a_sram_addr !== 16'h0000)
            $display("FAIL reset_regs: rdata=%h addr=%h expected 00/0000", a_rdata, a_sram_addr);
            else n_pass++;
        n_total++; if (b_busy !== 1'b0 || b_ce_n !== 1'b1)
            $display("FAIL reset_b: busy=%b ce_n=%b expected 0/1", b_busy, b_ce_n);
            else n_pass++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_read();
        int dk, bn, ol, wl, dn, fd; bit aok; logic [7:0] rv;
        run_txn(1'b0, 16'h1234, 8'h00, dk, bn, ol, wl, dn, fd, aok, rv);
        n_total++; if (dk !== 2 + WA) $display("FAIL read_done_k: got %0d expected %0d", dk, 2 + WA); else n_pass++;
        n_total++; if (bn !== 3 + WA) $display("FAIL read_busy: got %0d expected %0d", bn, 3 + WA); else n_pass++;
        n_total++; if (ol !== 2 + WA) $display("FAIL read_oe_low: got %0d expected %0d", ol, 2 + WA); else n_pass++;
        n_total++; if (wl !== 0) $display("FAIL read_we_low: got %0d expected 0", wl); else n_pass++;
        n_total++; if (!aok) $display("FAIL read_addr_stable: got unstable expected 1234"); else n_pass++;
        n_total++; if (rv !== 8'h5A) $display("FAIL read_data: got %h expected 5a", rv); else n_pass++;
        ref_rdata = ref_mem[16'h1234];
        @(posedge clock); #1;
        n_total++; if (a_rdata !== ref_rdata) $display("FAIL read_hold: got %h expected %h", a_rdata, ref_rdata); else n_pass++;
    endtask

    task automatic test_write();
        int dk, bn, ol, wl, dn, fd; bit aok; logic [7:0] rv;
        run_txn(1'b1, 16'hBEEF, 8'hC3, dk, bn, ol, wl, dn, fd, aok, rv);
        ref_mem[16'hBEEF] = 8'hC3;
        n_total++; if (dk !== 2 + WA) $display("FAIL write_done_k: got %0d expected %0d", dk, 2 + WA); else n_pass++;
        n_total++; if (wl !== 1 + WA) $display("FAIL write_we_low: got %0d expected %0d", wl, 1 + WA); else n_pass++;
        n_total++; if (ol !== 0) $display("FAIL write_oe_low: got %0d expected 0", ol); else n_pass++;
        n_total++; if (dn !== 2 + WA || fd !== 1)
            $display("FAIL write_drive: got %0d cycles from k=%0d expected %0d from k=1", dn, fd, 2 + WA);
            else n_pass++;
        n_total++; if (mem_a[16'hBEEF] !== 8'hC3) $display("FAIL write_mem: got %h expected c3", mem_a[16'hBEEF]); else n_pass++;
        n_total++; if (rv !== ref_rdata) $display("FAIL write_rdata_kept: got %h expected %h", rv, ref_rdata); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] prev_addr;
        prev_addr = a_sram_addr;
        @(posedge clock); #1;
        a_rd = 1'b1; a_wr = 1'b1; a_addr_bus = 16'h7777;
        @(posedge clock); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        n_total++; if (a_err !== 1'b1) $display("FAIL both_err: got %b expected 1", a_err); else n_pass++;
        n_total++; if (a_ce_n !== 1'b1 || a_busy !== 1'b0)
            $display("FAIL both_idle: ce_n=%b busy=%b expected 1/0", a_ce_n, a_busy); else n_pass++;
        n_total++; if (a_sram_addr !== prev_addr) $display("FAIL both_addr: got %h expected %h", a_sram_addr, prev_addr); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (a_err !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL both_pulse: err=%b busy=%b expected 0/0", a_err, a_busy); else n_pass++;
    endtask

    task automatic test_addr_float();
        logic [15:0] a1, a2; logic [7:0] d2; bit addr_ok; int second_k;
        a1 = 16'h0F0F; a2 = 16'h3C3C; d2 = 8'h69; addr_ok = 1'b1; second_k = 4 + WA;
        @(posedge clock); #1;
        a_addr_bus = a1; a_rd = 1'b1;
        @(posedge clock); #1;
        a_rd = 1'b0; a_addr_bus = 16'hzzzz;
        for (int k = 0; k < 2 * second_k; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (k == 2) begin a_addr_bus = a2; a_wdata = d2; a_wr = 1'b1; end
            if (k < second_k && a_sram_addr !== a1) addr_ok = 1'b0;
            if (k == 2 + WA) begin
                n_total++; if (a_done !== 1'b1 || a_rdata !== ref_mem[a1])
                    $display("FAIL float_first: done=%b rdata=%h expected 1/%h", a_done, a_rdata, ref_mem[a1]);
                    else n_pass++;
            end
            if (k == 3 + WA) begin
                n_total++; if (a_busy !== 1'b0) $display("FAIL float_gap: busy=%b expected 0", a_busy); else n_pass++;
            end
            if (k == second_k) begin
                a_wr = 1'b0;
                n_total++; if (a_busy !== 1'b1 || a_sram_addr !== a2)
                    $display("FAIL float_second: busy=%b addr=%h expected 1/%h", a_busy, a_sram_addr, a2);
                    else n_pass++;
            end
            if (k == second_k + 2 + WA) begin
                n_total++; if (a_done !== 1'b1) $display("FAIL float_second_done: got %b expected 1", a_done); else n_pass++;
            end
        end
        ref_rdata = ref_mem[a1];
        ref_mem[a2] = d2;
        n_total++; if (!addr_ok) $display("FAIL float_addr: got unstable expected %h", a1); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (mem_a[a2] !== d2) $display("FAIL float_mem: got %h expected %h", mem_a[a2], d2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a; int n_done; int span;
        a = 16'h2468; n_done = 0; span = 4 + WA;
        @(posedge clock); #1;
        a_addr_bus = a; a_rd = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 3 * span; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (a_done) begin
                n_total++; if (k !== 2 + WA + n_done * span || a_rdata !== ref_mem[a])
                    $display("FAIL b2b_done%0d: k=%0d rdata=%h expected k=%0d rdata=%h",
                             n_done, k, a_rdata, 2 + WA + n_done * span, ref_mem[a]);
                    else n_pass++;
                n_done++;
            end
        end
        a_rd = 1'b0;
        n_total++; if (n_done !== 3) $display("FAIL b2b_count: got %0d expected 3", n_done); else n_pass++;
        for (int k = 0; k < 20 && a_busy; k++) begin @(posedge clock); #1; end
        n_total++; if (a_busy !== 1'b0) $display("FAIL b2b_idle: busy=%b expected 0 (timeout)", a_busy); else n_pass++;
        ref_rdata = ref_mem[a];
    endtask

    task automatic test_random();
        int dk, bn, ol, wl, dn, fd; bit aok; logic [7:0] rv;
        bit is_wr; logic [15:0] a; logic [7:0] d; int errs;
        errs = 0;
        for (int t = 0; t < 40; t++) begin
            is_wr = 1'($urandom);
            a = (t % 4 == 3) ? 16'hBEEF : 16'($urandom);
            d = 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            run_txn(is_wr, a, d, dk, bn, ol, wl, dn, fd, aok, rv);
            if (!is_wr) ref_rdata = ref_mem[a];
            else ref_mem[a] = d;
            n_total++; if (dk !== 2 + WA || bn !== 3 + WA)
                $display("FAIL rnd%0d_timing: done_k=%0d busy=%0d expected %0d/%0d", t, dk, bn, 2 + WA, 3 + WA);
                else n_pass++;
            n_total++; if (ol !== (is_wr ? 0 : 2 + WA) || wl !== (is_wr ? 1 + WA : 0))
                $display("FAIL rnd%0d_strobes: oe_lo=%0d we_lo=%0d wr=%0b", t, ol, wl, is_wr);
                else n_pass++;
            n_total++; if (rv !== ref_rdata || !aok)
                $display("FAIL rnd%0d_data: rdata=%h addr_ok=%0b expected %h/1", t, rv, aok, ref_rdata);
                else n_pass++;
            if (is_wr) begin
                n_total++; if (mem_a[a] !== d || dn !== 2 + WA)
                    $display("FAIL rnd%0d_write: mem=%h drive=%0d expected %h/%0d", t, mem_a[a], dn, d, 2 + WA);
                    else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d; int dk, bn, ol, wl, dn, fd; bit aok; logic [7:0] rv;
        d = 8'h96;
        @(posedge clock); #1;
        a_addr_bus = 16'h4321; a_wdata = d; a_wr = 1'b1;
        @(posedge clock); #1;
        a_wr = 1'b0;
        @(posedge clock); #1;
        n_total++; if (a_we_n !== 1'b0 || a_sram_data !== d)
            $display("FAIL rst_pre: we_n=%b data=%h expected 0/%h", a_we_n, a_sram_data, d); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (a_we_n !== 1'b1 || a_ce_n !== 1'b1 || a_oe_n !== 1'b1)
            $display("FAIL rst_strobes: ce/oe/we=%b%b%b expected 111", a_ce_n, a_oe_n, a_we_n); else n_pass++;
        n_total++; if (a_sram_data === d)
            $display("FAIL rst_data_release: got %h expected released", a_sram_data); else n_pass++;
        n_total++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rdata !== 8'h00 || a_sram_addr !== 16'h0000)
            $display("FAIL rst_regs: busy=%b done=%b rdata=%h addr=%h expected 0/0/00/0000",
                     a_busy, a_done, a_rdata, a_sram_addr); else n_pass++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        ref_rdata = 8'h00;
        n_total++; if (a_busy !== 1'b0) $display("FAIL rst_idle: busy=%b expected 0", a_busy); else n_pass++;
        run_txn(1'b0, 16'h1234, 8'h00, dk, bn, ol, wl, dn, fd, aok, rv);
        ref_rdata = ref_mem[16'h1234];
        n_total++; if (dk !== 2 + WA || rv !== ref_rdata)
            $display("FAIL rst_recover: done_k=%0d rdata=%h expected %0d/%h", dk, rv, 2 + WA, ref_rdata); else n_pass++;
    endtask

    task automatic test_wait0();
        int done_k; int busy_n;
        done_k = -1; busy_n = 0;
        @(posedge clock); #1;
        b_addr_bus = 16'h0000; b_rd = 1'b1;
        @(posedge clock); #1;
        b_rd = 1'b0; b_addr_bus = 16'hzzzz;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (b_busy) busy_n++;
            if (b_done && done_k < 0) begin
                done_k = k;
                n_total++; if (b_rdata !== ref_mem[16'h0000])
                    $display("FAIL w0_data: got %h expected %h", b_rdata, ref_mem[16'h0000]); else n_pass++;
            end
            if (!b_busy) break;
        end
        n_total++; if (done_k !== 2 + WB) $display("FAIL w0_done_k: got %0d expected %0d", done_k, 2 + WB); else n_pass++;
        n_total++; if (busy_n !== 3 + WB) $display("FAIL w0_busy: got %0d expected %0d", busy_n, 3 + WB); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
        ref_rdata = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_simultaneous();
        test_addr_float();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        test_wait0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
